// File: rtl/q10_pkg.sv
// q10_pkg: shared Q10.10 widths, constants and the power FSM state encoding.
package q10_pkg;
   localparam int DATA_W    = 20;
   localparam int FRAC_BITS = 10;
   localparam logic [DATA_W-1:0] Q_ONE = 20'h00400;
   localparam logic [DATA_W-1:0] Q_MAX = 20'hFFFFF;
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/q10_mul_sat.sv
// q10_mul_sat: unsigned Q10.10 multiply with truncation and sticky saturation.
module q10_mul_sat
   import q10_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              in_sat,
   output logic [DATA_W-1:0] y,
   output logic              sat
);
   logic [2*DATA_W-1:0] w_prod;
   assign w_prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
   // Any integer bit above the Q10.10 range means the result no longer fits.
   assign sat = in_sat | (|w_prod[2*DATA_W-1:DATA_W+FRAC_BITS]);
   assign y   = sat ? Q_MAX : w_prod[DATA_W+FRAC_BITS-1:FRAC_BITS];
endmodule

// File: rtl/power_q10.sv
// power_q10: raises an unsigned Q10.10 base to a 0..7 integer power by
// repeated saturating multiplication, one multiply per cycle.
module power_q10
   import q10_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data_1,
   input  logic [2:0]        in_data_2,
   output logic              busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ovf
);
   state_t            r_state;
   logic [DATA_W-1:0] r_acc, r_x, r_out_data;
   logic [2:0]        r_n, r_cnt;
   logic              r_ovf, r_busy, r_out_valid, r_out_ovf;
   logic [DATA_W-1:0] w_y;
   logic              w_sat;
   q10_mul_sat u_mul (.a(r_acc), .b(r_x), .in_sat(r_ovf), .y(w_y), .sat(w_sat));
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_x         <= '0;
         r_n         <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= 1'b0;
         case (r_state)
            IDLE: if (in_valid) begin
               r_x     <= in_data_1;
               r_n     <= in_data_2;
               r_acc   <= Q_ONE;
               r_cnt   <= '0;
               r_ovf   <= 1'b0;
               r_busy  <= 1'b1;
               r_state <= (in_data_2 != 3'd0) ? MUL : DONE;
            end
            MUL: begin
               r_acc <= w_y;
               r_ovf <= w_sat;
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt == r_n - 3'd1) r_state <= DONE;
            end
            DONE: begin
               r_out_valid <= 1'b1;
               r_out_data  <= r_acc;
               r_out_ovf   <= r_ovf;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign busy      = r_busy;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_power_q10.sv
// tb_power_q10: directed checks of power_q10 latency, results, saturation,
// dropped requests while busy, back-to-back issue and mid-operation reset.
module tb_power_q10;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [19:0] in_data_1 = '0;
   logic [2:0]  in_data_2 = '0;
   logic        busy, out_valid, out_ovf;
   logic [19:0] out_data;
   int          checks = 0;
   int          failures = 0;
   logic        seen;

   power_q10 dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data_1(in_data_1),
      .in_data_2(in_data_2), .busy(busy), .out_valid(out_valid),
      .out_data(out_data), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic start(input logic [19:0] x, input logic [2:0] n);
      in_data_1 = x;
      in_data_2 = n;
      in_valid  = 1'b1;
   endtask

   // Called right after start(): walks cycles T+1..T+n+2 on falling edges.
   task automatic finish_req(input string tag, input int n, input logic [19:0] exp,
                             input logic exp_ovf, input logic extra);
      for (int k = 1; k <= n + 2; k++) begin
         @(negedge clk);
         in_data_1 = 20'hABCDE;
         in_data_2 = 3'd7;
         in_valid  = extra && (k <= n + 1);
         if (k <= n + 1) begin
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_nov"}, out_valid, 1'b0);
         end else begin
            chk({tag, "_ov"}, out_valid, 1'b1);
            chk({tag, "_data"}, out_data, exp);
            chk({tag, "_ovf"}, out_ovf, exp_ovf);
            chk({tag, "_idle"}, busy, 1'b0);
         end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_data", out_data, 20'h0);
      chk("rst_ovf", out_ovf, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      start(20'h00800, 3'd3); finish_req("pow2_3", 3, 20'h02000, 1'b0, 1'b0);
      @(negedge clk);
      chk("pow2_3_clear", out_data, 20'h0);
      start(20'h00600, 3'd2); finish_req("p15_2", 2, 20'h00900, 1'b0, 1'b0);
      start(20'h00001, 3'd2); finish_req("trunc", 2, 20'h00000, 1'b0, 1'b0);
      start(20'h12345, 3'd0); finish_req("n0", 0, 20'h00400, 1'b0, 1'b0);
      start(20'h00000, 3'd0); finish_req("x0n0", 0, 20'h00400, 1'b0, 1'b0);
      start(20'h00000, 3'd5); finish_req("x0n5", 5, 20'h00000, 1'b0, 1'b0);
      start(20'h0C000, 3'd7); finish_req("sat", 7, 20'hFFFFF, 1'b1, 1'b0);
      start(20'h7FC00, 3'd1); finish_req("big1", 1, 20'h7FC00, 1'b0, 1'b0);
      @(negedge clk);

      start(20'h00600, 3'd3); finish_req("extra", 3, 20'h00D80, 1'b0, 1'b1);
      @(negedge clk);
      chk("extra_dropped_ov", out_valid, 1'b0);
      chk("extra_dropped_busy", busy, 1'b0);

      start(20'h00800, 3'd2); finish_req("b2b_a", 2, 20'h01000, 1'b0, 1'b0);
      start(20'h00C00, 3'd2); finish_req("b2b_b", 2, 20'h02400, 1'b0, 1'b0);
      @(negedge clk);

      start(20'h0C000, 3'd7);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ov", out_valid, 1'b0);
      chk("mid_rst_data", out_data, 20'h0);
      chk("mid_rst_ovf", out_ovf, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen = seen | out_valid | busy;
      end
      chk("mid_rst_quiet", seen, 1'b0);
      start(20'h00800, 3'd1); finish_req("post_rst", 1, 20'h00800, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
